apb_master_port: RTL and testbench

- APB3 requester that drives transactions into the register-bank slaves: the CPU-side write path into the register fields.
- Accepts one command at a time on a valid/ready interface.
- Sequences the APB SETUP and ACCESS phases and honours slave wait states.
- Returns read data and error status on a valid/ready response interface.

---
 rtl/apb_master_port.sv | 129 ++++++++++++
 tb/tb_apb_master_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_port.sv
// APB3 requester: one command at a time, SETUP/ACCESS sequencing.
// Optional ACCESS timeout abort under APB_MASTER_TIMEOUT_EN.
module apb_master_port #(
  parameter int TP             = 1,
  parameter int AWIDTH         = 32,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef APB_MASTER_TIMEOUT_EN
  output logic              rsp_timeout,
`endif
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AWIDTH-1:0] paddr,
  output logic [DWIDTH-1:0] pwdata,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // TP is kept for drop-in compatibility; RTL models no delays.
  if (TP < 0) begin : g_tp_unused
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_unused
  end

  logic [1:0] state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
`endif

  // Commands are only taken while idle.
  always_comb begin
    cmd_ready = (state == S_IDLE);
  end

  // Transfer sequencer and response holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_port.sv
// Directed bench for apb_master_port.
// Timeout cases build only with APB_MASTER_TIMEOUT_EN.
module tb_apb_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
  logic        rsp_timeout;
`endif
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb_master_port #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
`ifdef APB_MASTER_TIMEOUT_EN
    .rsp_timeout(rsp_timeout),
`endif
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    // zero-wait write
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("zw_setup_psel", 32'(psel), 32'd1);
    chk("zw_setup_pen", 32'(penable), 32'd0);
    chk("zw_setup_rdy", 32'(cmd_ready), 32'd0);
    chk("zw_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("zw_paddr", paddr, 32'h10);
    chk("zw_pwrite", 32'(pwrite), 32'd1);
    tick();
    chk("zw_acc_psel", 32'(psel), 32'd1);
    chk("zw_acc_pen", 32'(penable), 32'd1);
    chk("zw_acc_rv", 32'(rsp_valid), 32'd0);
    tick();
    chk("zw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("zw_rsp_psel", 32'(psel), 32'd0);
    chk("zw_rsp_err", 32'(rsp_err), 32'd0);
    chk("zw_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("zw_idle_rv", 32'(rsp_valid), 32'd0);
    chk("zw_idle_rdy", 32'(cmd_ready), 32'd1);
    chk("zw_keep_addr", paddr, 32'h10);

    // wait-state read; noise on prdata/pslverr while waiting
    pready  = 1'b0;
    pslverr = 1'b1;
    prdata  = 32'hCAFE_0000;
    issue(1'b0, 32'h20, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ws_psel", 32'(psel), 32'd1);
      chk("ws_pen", 32'(penable), 32'd1);
      chk("ws_paddr", paddr, 32'h20);
      tick();
    end
    chk("ws_last_pen", 32'(penable), 32'd1);
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 32'h1234_5678;
    tick();
    chk("ws_rv", 32'(rsp_valid), 32'd1);
    chk("ws_rdata", rsp_rdata, 32'h1234_5678);
    chk("ws_err", 32'(rsp_err), 32'd0);
    tick();

    // slave error then clean transfer
    pslverr = 1'b1;
    prdata  = 32'h7777_7777;
    issue(1'b1, 32'h30, 32'h55);
    tick();
    tick();
    chk("se_rv", 32'(rsp_valid), 32'd1);
    chk("se_err", 32'(rsp_err), 32'd1);
    chk("se_rdata", rsp_rdata, 32'd0);
    pslverr = 1'b0;
    prdata  = 32'h0BAD_F00D;
    tick();
    chk("se_keep_addr", paddr, 32'h30);
    chk("se_keep_wd", pwdata, 32'h55);
    issue(1'b0, 32'h34, 32'h0);
    tick();
    tick();
    chk("se2_err", 32'(rsp_err), 32'd0);
    chk("se2_rdata", rsp_rdata, 32'h0BAD_F00D);
    tick();

    // response backpressure with a command waiting
    rsp_ready = 1'b0;
    prdata    = 32'h600D_CAFE;
    issue(1'b0, 32'h40, 32'h0);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h50;
    cmd_wdata = 32'hA5A5_A5A5;
    prdata    = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h600D_CAFE);
      chk("bp_rdy", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(psel), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rv_clr", 32'(rsp_valid), 32'd0);
    chk("bp_idle_rdy", 32'(cmd_ready), 32'd1);
    chk("bp_idle_psel", 32'(psel), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_psel", 32'(psel), 32'd1);
    chk("bp_next_addr", paddr, 32'h50);
    chk("bp_next_wd", pwdata, 32'hA5A5_A5A5);
    tick();
    tick();
    chk("bp_next_rv", 32'(rsp_valid), 32'd1);
    chk("bp_next_rd", rsp_rdata, 32'd0);
    tick();

    // reset mid-transfer
    pready = 1'b0;
    issue(1'b0, 32'h60, 32'h0);
    tick();
    chk("rm_acc_pen", 32'(penable), 32'd1);
    rst = 1'b1;
    tick();
    chk("rm_psel", 32'(psel), 32'd0);
    chk("rm_pen", 32'(penable), 32'd0);
    chk("rm_paddr", paddr, 32'd0);
    rst    = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rm_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rm_rdy", 32'(cmd_ready), 32'd1);
      tick();
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // full timeout
    pready = 1'b0;
    issue(1'b1, 32'h70, 32'h1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_psel", 32'(psel), 32'd1);
      chk("to_wait_rv", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("to_rv", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_psel", 32'(psel), 32'd0);
    tick();

    // pready on the limit cycle wins
    issue(1'b0, 32'h74, 32'h0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("tl_still_acc", 32'(penable), 32'd1);
    pready = 1'b1;
    prdata = 32'h8765_4321;
    tick();
    chk("tl_rv", 32'(rsp_valid), 32'd1);
    chk("tl_flag", 32'(rsp_timeout), 32'd0);
    chk("tl_err", 32'(rsp_err), 32'd0);
    chk("tl_rdata", rsp_rdata, 32'h8765_4321);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
